// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Issue stage in front of a combinational ALU. Commands are buffered in a small
// FIFO and issued one at a time. Each command's operands and select are
// registered into the ALU. The ALU result is then captured into a result
// register and an accumulator, and offered on a valid/ready result port.
// A command may take the accumulator as operand a. This chains dependent
// operations without reading the result back.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready = FIFO not full)
//   cmd_sel/cmd_a/cmd_b           ALU select and operands
//   cmd_use_acc                   1: operand a is taken from the accumulator
//   alu_a/alu_b/alu_sel           registered operands/select driven to the ALU
//   alu_res/alu_carry             combinational ALU result and carry
//   res_valid/res_ready           result handshake
//   res_data/res_carry/res_zero   captured result, carry, zero flag
//   acc                           accumulator (last captured result)
//   busy                          operation in flight or commands queued
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [SEL_W-1:0] cmd_sel,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero,
    output logic [WIDTH-1:0] acc,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = SEL_W + 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;

    logic [EW-1:0]     fifo_mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic              empty_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;

    logic [SEL_W-1:0]  head_sel_s;
    logic [WIDTH-1:0]  head_a_s;
    logic [WIDTH-1:0]  head_b_s;
    logic              head_use_acc_s;

    logic [WIDTH-1:0]  alu_a_r;
    logic [WIDTH-1:0]  alu_b_r;
    logic [SEL_W-1:0]  alu_sel_r;
    logic              res_valid_r;
    logic [WIDTH-1:0]  res_data_r;
    logic              res_carry_r;
    logic [WIDTH-1:0]  acc_r;

    // Pointers carry one extra wrap bit. Equal pointers mean empty. Differing
    // only in the wrap bit means full.
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    // cmd_ready depends only on stored state. A pop in the same cycle does not
    // reopen a full FIFO.
    assign push_s  = cmd_valid && !full_s;
    assign pop_s   = (state_r == ST_ISSUE) && !empty_s;

    assign {head_sel_s, head_a_s, head_b_s, head_use_acc_s} = fifo_mem_r[rd_ptr_r[AW-1:0]];

    // Command storage write port (contents need no reset; validity is in the pointers)
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[AW-1:0]] <= {cmd_sel, cmd_a, cmd_b, cmd_use_acc};
        end
    end

    // FIFO read/write pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
        end
    end

    // Issue FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Issue FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) state_s = ST_ISSUE;
                else          state_s = ST_IDLE;
            end
            ST_ISSUE: begin
                // An empty FIFO cannot occur here. Fall back to IDLE rather than issue stale data.
                if (!empty_s) state_s = ST_EXEC;
                else          state_s = ST_IDLE;
            end
            ST_EXEC: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    // A command pushed in this same cycle counts as pending
                    if (!empty_s || push_s) state_s = ST_ISSUE;
                    else                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // ALU operand registers, result capture, accumulator and result-valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_r     <= {WIDTH{1'b0}};
            alu_b_r     <= {WIDTH{1'b0}};
            alu_sel_r   <= {SEL_W{1'b0}};
            res_valid_r <= 1'b0;
            res_data_r  <= {WIDTH{1'b0}};
            res_carry_r <= 1'b0;
            acc_r       <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_ISSUE: begin
                    if (pop_s) begin
                        // Only one op is in flight, so acc_r already holds the previous result
                        alu_a_r   <= head_use_acc_s ? acc_r : head_a_s;
                        alu_b_r   <= head_b_s;
                        alu_sel_r <= head_sel_s;
                    end
                end
                ST_EXEC: begin
                    res_data_r  <= alu_res;
                    res_carry_r <= alu_carry;
                    acc_r       <= alu_res;
                    res_valid_r <= 1'b1;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                    end
                end
                default: begin
                    res_valid_r <= res_valid_r;
                end
            endcase
        end
    end

    assign cmd_ready = !full_s;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_sel   = alu_sel_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_carry = res_carry_r;
    assign res_zero  = (res_data_r == {WIDTH{1'b0}});
    assign acc       = acc_r;
    assign busy      = (state_r != ST_IDLE) || !empty_s;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed self-checking bench for alu_issue_ctrl. A small ALU model drives
// alu_res/alu_carry: sel=000 is a+b with carry out, and any other select is
// a^b with carry 0. Expected results are hand-written constants or come from a
// reference model of the command stream.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_sel;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        cmd_use_acc;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_sel;
    logic [31:0] alu_res;
    logic        alu_carry;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_carry;
    logic        res_zero;
    logic [31:0] acc;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        use_acc;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [32:0] exp_q[$];
    logic [31:0] model_acc = 32'h0;

    alu_issue_ctrl #(.WIDTH(32), .SEL_W(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_res(alu_res), .alu_carry(alu_carry),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero),
        .acc(acc), .busy(busy)
    );

    // Bench ALU model
    assign {alu_carry, alu_res} = (alu_sel == 3'b000) ? ({1'b0, alu_a} + {1'b0, alu_b})
                                                      : {1'b0, alu_a ^ alu_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic use_acc);
        cmd_t        c;
        logic [31:0] opa;
        logic [32:0] r;
        c.sel = sel; c.a = a; c.b = b; c.use_acc = use_acc;
        cmd_q.push_back(c);
        opa = use_acc ? model_acc : a;
        if (sel == 3'b000) r = {1'b0, opa} + {1'b0, b};
        else               r = {1'b0, opa ^ b};
        exp_q.push_back(r);
        model_acc = r[31:0];
    endtask

    task automatic drive_head();
        if (cmd_q.size() > 0) begin
            cmd_valid   = 1'b1;
            cmd_sel     = cmd_q[0].sel;
            cmd_a       = cmd_q[0].a;
            cmd_b       = cmd_q[0].b;
            cmd_use_acc = cmd_q[0].use_acc;
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    // Pushes queued commands whenever accepted and checks results in order (res_ready=1)
    task automatic run_stream(input string tag, input int budget);
        int          cyc;
        logic        took;
        logic [32:0] e;
        cyc = 0;
        while ((cmd_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            if (res_valid && res_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk({tag, "_res"}, {31'h0, res_carry, res_data}, {31'h0, e});
                end else begin
                    chk({tag, "_extra_res"}, res_valid, 1'b0);
                end
            end
            drive_head();
            took = cmd_valid && cmd_ready;
            step();
            if (took) cmd_q.delete(0);
            cyc++;
        end
        cmd_valid = 1'b0;
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_sel = 3'b000; cmd_a = 32'h0; cmd_b = 32'h0;
        cmd_use_acc = 1'b0; res_ready = 1'b0;

        // ---- reset state ----
        step(); step();
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_acc", acc, 32'h0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        step();

        // ---- single op with exact latency ----
        res_ready = 1'b1;
        cmd_valid = 1'b1; cmd_sel = 3'b000; cmd_a = 32'hFFFF_FFFF; cmd_b = 32'h1; cmd_use_acc = 1'b0;
        step();                                   // edge T: push
        cmd_valid = 1'b0;
        chk("single_busy", busy, 1'b1);
        chk("single_valid_t0", res_valid, 1'b0);
        step();                                   // T+1: enter ISSUE
        step();                                   // T+2: operands loaded
        chk("single_valid_t2", res_valid, 1'b0);
        chk("single_alu_a", alu_a, 32'hFFFF_FFFF);
        chk("single_alu_b", alu_b, 32'h1);
        step();                                   // T+3: captured
        chk("single_valid_t3", res_valid, 1'b1);
        chk("single_data", res_data, 32'h0);
        chk("single_carry", res_carry, 1'b1);
        chk("single_zero", res_zero, 1'b1);
        chk("single_acc", acc, 32'h0);
        step();                                   // handshake
        chk("single_valid_drop", res_valid, 1'b0);
        chk("single_idle", busy, 1'b0);
        chk("single_data_hold", res_data, 32'h0);

        // ---- accumulator chain: 5+7=12, then acc+10=22 ----
        model_acc = 32'h0;
        enq(3'b000, 32'h5, 32'h7, 1'b0);
        enq(3'b000, 32'hDEAD_BEEF, 32'hA, 1'b1);
        run_stream("chain", 40);
        chk("chain_alu_a", alu_a, 32'hC);
        chk("chain_acc", acc, 32'h16);
        chk("chain_zero", res_zero, 1'b0);

        // ---- FIFO full / backpressure ----
        res_ready = 1'b0;
        for (int k = 0; k < 6; k++) enq(3'b000, 32'(k + 1), 32'h100, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive_head();
            chk("full_ready_pre", cmd_ready, 1'b1);
            step();
            cmd_q.delete(0);
        end
        drive_head();                             // 6th command held pending
        chk("full_ready_low", cmd_ready, 1'b0);

        // ---- result hold with res_ready low ----
        for (int k = 0; k < 10; k++) begin
            step();
            chk("hold_valid", res_valid, 1'b1);
            chk("hold_data", res_data, 32'h101);
            chk("hold_carry", res_carry, 1'b0);
            chk("hold_ready", cmd_ready, 1'b0);
        end
        chk("hold_no_issue", alu_a, 32'h1);
        res_ready = 1'b1;
        run_stream("full", 80);
        chk("full_6th_taken", cmd_q.size(), 0);

        // ---- streaming with simultaneous push/pop across pointer wrap ----
        for (int i = 0; i < 12; i++) begin
            enq((i == 5) ? 3'b011 : 3'b000, 32'h2000_0001 * 32'(i + 1),
                32'hF000_0000 - 32'(i), (i % 3) == 2);
        end
        run_stream("stream", 200);

        // ---- async reset mid-EXEC ----
        cmd_valid = 1'b1; cmd_sel = 3'b000; cmd_a = 32'h1234_5678; cmd_b = 32'h1; cmd_use_acc = 1'b0;
        step();                                   // push A
        cmd_a = 32'h0000_0042;
        step();                                   // push B, state ISSUE
        cmd_valid = 1'b0;
        step();                                   // state EXEC
        chk("mid_alu_a", alu_a, 32'h1234_5678);
        chk("mid_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_alu_a", alu_a, 32'h0);
        chk("arst_alu_b", alu_b, 32'h0);
        chk("arst_alu_sel", alu_sel, 3'b000);
        chk("arst_res_data", res_data, 32'h0);
        chk("arst_res_carry", res_carry, 1'b0);
        chk("arst_acc", acc, 32'h0);
        chk("arst_res_valid", res_valid, 1'b0);
        chk("arst_cmd_ready", cmd_ready, 1'b1);
        chk("arst_busy", busy, 1'b0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("post_rst_valid", res_valid, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
        end
        chk("post_rst_alu_a", alu_a, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
